// File: rtl/rect_fill_drawer.sv
// rect_fill_drawer
// Rectangle-fill drawing engine feeding a framebuffer plot port.
// A command (x0, y0, w, h, colour) is taken through a valid/ready
// handshake, clipped to the SCREEN_W x SCREEN_H screen, and written out
// as one pixel per clock in row-major order. A one-cycle done pulse
// marks the end of each command, including commands that clip to nothing.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_x0, cmd_y0        top-left corner of the rectangle
//   cmd_w, cmd_h          rectangle size in pixels
//   cmd_colour            fill colour
//   x, y, colour, plot    pixel write to the adapter, one pixel per plot cycle
//   busy                  a command is being drawn or finishing
//   done                  one-cycle pulse when a command finishes
module rect_fill_drawer #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int XW          = 8,
  parameter int YW          = 7,
  parameter int COLOUR_BITS = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [XW-1:0]          cmd_x0,
  input  logic [YW-1:0]          cmd_y0,
  input  logic [XW-1:0]          cmd_w,
  input  logic [YW-1:0]          cmd_h,
  input  logic [COLOUR_BITS-1:0] cmd_colour,
  output logic [XW-1:0]          x,
  output logic [YW-1:0]          y,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_t;

  localparam logic [XW:0] SW_E = (XW+1)'(SCREEN_W);
  localparam logic [YW:0] SH_E = (YW+1)'(SCREEN_H);

  // Clipped extent along x: min(len, SCREEN_W - org), one bit wider so
  // the subtraction and a full-width length cannot overflow.
  function automatic logic [XW:0] clip_x(input logic [XW-1:0] org,
                                         input logic [XW-1:0] len);
    logic [XW:0] rem;
    logic [XW:0] len_e;
    rem   = SW_E - {1'b0, org};
    len_e = {1'b0, len};
    return (len_e < rem) ? len_e : rem;
  endfunction

  function automatic logic [YW:0] clip_y(input logic [YW-1:0] org,
                                         input logic [YW-1:0] len);
    logic [YW:0] rem;
    logic [YW:0] len_e;
    rem   = SH_E - {1'b0, org};
    len_e = {1'b0, len};
    return (len_e < rem) ? len_e : rem;
  endfunction

  state_t                 state_q, state_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [COLOUR_BITS-1:0] colour_q, colour_d;
  logic [XW-1:0]          x0_q, x0_d;
  logic [XW-1:0]          xend_q, xend_d;
  logic [YW-1:0]          yend_q, yend_d;

  logic                   cmd_empty;
  logic [XW:0]            ew;
  logic [YW:0]            eh;
  logic [XW:0]            xend_e;
  logic [YW:0]            yend_e;

  // Accept-time clipping: extents and inclusive end coordinates.
  always_comb begin
    cmd_empty = ({1'b0, cmd_x0} >= SW_E) || ({1'b0, cmd_y0} >= SH_E) ||
                (cmd_w == '0) || (cmd_h == '0);
    ew        = clip_x(cmd_x0, cmd_w);
    eh        = clip_y(cmd_y0, cmd_h);
    xend_e    = {1'b0, cmd_x0} + ew - (XW+1)'(1);
    yend_e    = {1'b0, cmd_y0} + eh - (YW+1)'(1);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    x0_d     = x0_q;
    xend_d   = xend_q;
    yend_d   = yend_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_empty) begin
            // Nothing to draw: pixel outputs keep their last values.
            state_d = S_DONE;
          end else begin
            state_d  = S_DRAW;
            x_d      = cmd_x0;
            y_d      = cmd_y0;
            colour_d = cmd_colour;
            x0_d     = cmd_x0;
            xend_d   = xend_e[XW-1:0];
            yend_d   = yend_e[YW-1:0];
          end
        end
      end
      S_DRAW: begin
        if (x_q == xend_q) begin
          if (y_q == yend_q) begin
            // Last pixel: leave x/y on it so they hold once plot drops.
            state_d = S_DONE;
          end else begin
            x_d = x0_q;
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State boundary: everything registered on the rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      x0_q     <= '0;
      xend_q   <= '0;
      yend_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      x0_q     <= x0_d;
      xend_q   <= xend_d;
      yend_q   <= yend_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign plot      = (state_q == S_DRAW);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_DRAW) || (state_q == S_DONE);
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;

endmodule

// File: tb/tb_rect_fill_drawer.sv
// Bench for rect_fill_drawer: a queue-based model predicts every cycle's
// outputs from each accepted command; directed tests add literal checks.
module tb_rect_fill_drawer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x0 = '0;
  logic [6:0] cmd_y0 = '0;
  logic [7:0] cmd_w = '0;
  logic [6:0] cmd_h = '0;
  logic [2:0] cmd_colour = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  rect_fill_drawer dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_colour(cmd_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit       plot;
    bit       done;
    bit       busy;
    bit [7:0] x;
    bit [6:0] y;
    bit [2:0] c;
  } rec_t;

  rec_t     mq[$];
  bit [7:0] hx = '0;
  bit [6:0] hy = '0;
  bit [2:0] hc = '0;
  bit       armed = 1'b0;

  int errors = 0;
  int checks = 0;

  int       plot_cnt = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
  bit [7:0] cap_x[$];
  bit [6:0] cap_y[$];
  bit [2:0] cap_c[$];

  function automatic rec_t mk(bit p, bit d, bit b, int xx, int yy, int cc);
    rec_t r;
    r.plot = p; r.done = d; r.busy = b;
    r.x = xx[7:0]; r.y = yy[6:0]; r.c = cc[2:0];
    return r;
  endfunction

  // Expands one accepted command into the per-cycle outputs that must follow.
  function automatic void model_accept(int x0, int y0, int w, int h, int c);
    int ew, eh;
    ew = (x0 >= 160) ? 0 : ((w < 160 - x0) ? w : 160 - x0);
    eh = (y0 >= 120) ? 0 : ((h < 120 - y0) ? h : 120 - y0);
    if (ew > 0 && eh > 0) begin
      for (int r = 0; r < eh; r++)
        for (int col = 0; col < ew; col++)
          mq.push_back(mk(1, 0, 1, x0 + col, y0 + r, c));
      hx = 8'(x0 + ew - 1);
      hy = 7'(y0 + eh - 1);
      hc = 3'(c);
    end
    mq.push_back(mk(0, 1, 1, hx, hy, hc));
  endfunction

  task automatic chk(bit ok, string name, int act, int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Compare process: outputs seen here reflect the state after the last
  // rising edge; inputs seen here are the ones the next edge will sample.
  always @(negedge clock) begin
    rec_t        cur;
    bit          was_idle;
    logic [21:0] act, expv;
    if (mq.size() != 0) cur = mq[0];
    else cur = mk(0, 0, 0, hx, hy, hc);
    if (armed) begin
      act  = {plot, done, busy, cmd_ready, x, y, colour};
      expv = {cur.plot, cur.done, cur.busy, ~cur.busy, cur.x, cur.y, cur.c};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL cycle_model: {plot,done,busy,rdy,x,y,c} got %h expected %h (t=%0t)",
                 act, expv, $time);
      end
    end
    if (plot === 1'b1) begin
      plot_cnt++;
      cap_x.push_back(x); cap_y.push_back(y); cap_c.push_back(colour);
    end
    if (done === 1'b1) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
    end
    was_idle = (mq.size() == 0);
    if (reset) begin
      mq.delete();
      hx = '0; hy = '0; hc = '0;
      armed = 1'b1;
    end else begin
      if (!was_idle) void'(mq.pop_front());
      if (was_idle && cmd_valid)
        model_accept(int'(cmd_x0), int'(cmd_y0), int'(cmd_w), int'(cmd_h), int'(cmd_colour));
    end
  end

  task automatic clear_cap();
    plot_cnt = 0; done_cnt = 0; done_cyc = -1;
    cap_x.delete(); cap_y.delete(); cap_c.delete();
  endtask

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clock);
      if (cmd_ready === 1'b1) break;
      n++;
      if (n > 30000) begin
        chk(0, "accept_timeout", n, 0);
        break;
      end
    end
    @(posedge clock);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic send(int x0, int y0, int w, int h, int c);
    @(posedge clock);
    #1;
    cmd_x0 = 8'(x0); cmd_y0 = 7'(y0); cmd_w = 8'(w); cmd_h = 7'(h); cmd_colour = 3'(c);
    cmd_valid = 1'b1;
    wait_accept();
    cmd_valid = 1'b0;
    // Fields only need to be valid in the accept cycle.
    cmd_x0 = 8'($urandom); cmd_y0 = 7'($urandom); cmd_w = 8'($urandom);
    cmd_h = 7'($urandom); cmd_colour = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clock);
      #2;
      n++;
    end while (mq.size() != 0 && n < 25000);
    if (mq.size() != 0) chk(0, "idle_timeout", n, 25000);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic chk_px(int i, int ex, int ey, int ec);
    if (i < cap_x.size()) begin
      chk(cap_x[i] == 8'(ex), $sformatf("px%0d_x", i), cap_x[i], ex);
      chk(cap_y[i] == 7'(ey), $sformatf("px%0d_y", i), cap_y[i], ey);
      chk(cap_c[i] == 3'(ec), $sformatf("px%0d_c", i), cap_c[i], ec);
    end else begin
      chk(0, $sformatf("px%0d_missing", i), cap_x.size(), i + 1);
    end
  endtask

  int ex1[6] = '{10, 11, 12, 10, 11, 12};
  int ey1[6] = '{20, 20, 20, 21, 21, 21};
  int ex2[4] = '{158, 159, 158, 159};
  int ey2[4] = '{118, 118, 119, 119};
  int a1, a2;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk(plot === 1'b0 && done === 1'b0 && busy === 1'b0, "reset_ctrl", {plot, done, busy}, 0);
    chk(cmd_ready === 1'b1, "reset_ready", cmd_ready, 1);
    chk(x === 8'd0 && y === 7'd0 && colour === 3'd0, "reset_xyc", {x, y, colour}, 0);

    // Basic 3x2 fill
    clear_cap();
    send(10, 20, 3, 2, 5);
    wait_idle();
    chk(plot_cnt == 6, "t1_plot_cnt", plot_cnt, 6);
    chk(done_cnt == 1, "t1_done_cnt", done_cnt, 1);
    chk(done_cyc - acc_cyc == 6, "t1_done_lat", done_cyc - acc_cyc, 6);
    for (int i = 0; i < 6; i++) chk_px(i, ex1[i], ey1[i], 5);

    // Clipped at the bottom-right corner
    clear_cap();
    send(158, 118, 5, 5, 2);
    wait_idle();
    chk(plot_cnt == 4, "t2_plot_cnt", plot_cnt, 4);
    chk(done_cyc - acc_cyc == 4, "t2_done_lat", done_cyc - acc_cyc, 4);
    for (int i = 0; i < 4; i++) chk_px(i, ex2[i], ey2[i], 2);

    // Empty commands
    for (int k = 0; k < 4; k++) begin
      clear_cap();
      case (k)
        0: send(5, 5, 0, 3, 1);
        1: send(160, 5, 2, 2, 1);
        2: send(5, 120, 2, 2, 1);
        default: send(5, 5, 3, 0, 1);
      endcase
      wait_idle();
      chk(plot_cnt == 0, $sformatf("t3_%0d_plot_cnt", k), plot_cnt, 0);
      chk(done_cnt == 1, $sformatf("t3_%0d_done_cnt", k), done_cnt, 1);
      chk(done_cyc - acc_cyc == 0, $sformatf("t3_%0d_done_lat", k), done_cyc - acc_cyc, 0);
    end
    chk(x === 8'd159 && y === 7'd119, "t3_hold_xy", {x, y}, {8'd159, 7'd119});

    // Full screen with an ignored command pulse while busy
    clear_cap();
    send(0, 0, 160, 120, 7);
    repeat (100) @(posedge clock);
    #1;
    cmd_x0 = 8'd1; cmd_y0 = 7'd1; cmd_w = 8'd1; cmd_h = 7'd1; cmd_colour = 3'd1;
    cmd_valid = 1'b1;
    @(negedge clock);
    chk(cmd_ready === 1'b0, "t4_ready_busy", cmd_ready, 0);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    wait_idle();
    chk(plot_cnt == 19200, "t4_plot_cnt", plot_cnt, 19200);
    chk(done_cyc - acc_cyc == 19200, "t4_contiguous", done_cyc - acc_cyc, 19200);
    chk(done_cnt == 1, "t4_done_cnt", done_cnt, 1);
    chk_px(19199, 159, 119, 7);

    // Reset after the 5th pixel of a 10x10 fill
    clear_cap();
    send(0, 0, 10, 10, 6);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk(plot_cnt == 5, "t5_plot_cnt", plot_cnt, 5);
    chk(done_cnt == 0, "t5_no_done", done_cnt, 0);
    chk(cmd_ready === 1'b1, "t5_ready", cmd_ready, 1);
    clear_cap();
    send(0, 0, 1, 1, 3);
    wait_idle();
    chk(plot_cnt == 1, "t5_1x1_cnt", plot_cnt, 1);
    chk_px(0, 0, 0, 3);

    // Back-to-back with cmd_valid held high
    clear_cap();
    @(posedge clock);
    #1;
    cmd_x0 = 8'd3; cmd_y0 = 7'd4; cmd_w = 8'd1; cmd_h = 7'd1; cmd_colour = 3'd1;
    cmd_valid = 1'b1;
    wait_accept();
    a1 = acc_cyc;
    cmd_x0 = 8'd7; cmd_y0 = 7'd8; cmd_colour = 3'd2;
    wait_accept();
    a2 = acc_cyc;
    cmd_valid = 1'b0;
    wait_idle();
    chk(a2 - a1 == 3, "t6_accept_gap", a2 - a1, 3);
    chk(plot_cnt == 2, "t6_plot_cnt", plot_cnt, 2);
    chk(done_cnt == 2, "t6_done_cnt", done_cnt, 2);
    chk_px(0, 3, 4, 1);
    chk_px(1, 7, 8, 2);

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
